// File: rtl/mem_demux_stream_pkg.sv
// Shared definitions for the memory demux stream: header codes, FSM states,
// and the mapping from a data header to its output channel.
package mem_demux_stream_pkg;

    localparam logic [3:0] HDR_IDLE   = 4'b0000;
    localparam logic [3:0] HDR_MARKER = 4'b1111;
    localparam logic [3:0] HDR_CH0    = 4'b0100;
    localparam logic [3:0] HDR_CH1    = 4'b0101;
    localparam logic [3:0] HDR_CH2    = 4'b0010;
    localparam logic [3:0] HDR_CH3    = 4'b0011;
    localparam logic [3:0] HDR_CH4    = 4'b1000;
    localparam logic [3:0] HDR_CH5    = 4'b1001;
    localparam logic [3:0] HDR_CH6    = 4'b1010;

    localparam int NUM_CHAN = 8;

    typedef enum logic {
        WAIT_SYNC = 1'b0,
        RUN       = 1'b1
    } state_t;

    function automatic logic hdr_is_data(input logic [3:0] hdr);
        case (hdr)
            HDR_CH0, HDR_CH1, HDR_CH2, HDR_CH3,
            HDR_CH4, HDR_CH5, HDR_CH6: return 1'b1;
            default:                   return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] hdr_to_chan(input logic [3:0] hdr);
        return {hdr[3], hdr[1:0]};
    endfunction

endpackage

// File: rtl/mem_demux_chan_cnt.sv
// Per-channel entry counter that saturates at 2^ADDR_W and snapshots its
// value into nentries when a BX closes.
module mem_demux_chan_cnt #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_i,
    input  logic              inc_i,
    input  logic              snap_i,
    output logic [ADDR_W:0]   count_o,
    output logic              full_o,
    output logic [ADDR_W:0]   nentries_o
);

    logic [ADDR_W:0] count_q, count_d;
    logic [ADDR_W:0] nentries_q, nentries_d;

    always_comb begin
        count_d    = count_q;
        nentries_d = nentries_q;
        if (snap_i) begin
            nentries_d = count_q;
        end
        if (clear_i) begin
            count_d = '0;
        end else if (inc_i && !count_q[ADDR_W]) begin
            count_d = count_q + (ADDR_W+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q    <= '0;
            nentries_q <= '0;
        end else begin
            count_q    <= count_d;
            nentries_q <= nentries_d;
        end
    end

    assign count_o    = count_q;
    assign full_o     = count_q[ADDR_W];
    assign nentries_o = nentries_q;

endmodule

// File: rtl/mem_demux_stream.sv
// Demultiplexes a tagged 55-bit word stream into 8 paged memory write ports,
// framing entries by BX markers and flagging stream errors.
module mem_demux_stream
    import mem_demux_stream_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int PAGE_W = 2
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [54:0]                         mem_dat_stream,
    output logic [50:0]                         dat_out,
    output logic [NUM_CHAN-1:0]                 wr_en,
    output logic [NUM_CHAN-1:0][PAGE_W+ADDR_W-1:0] wr_addr,
    output logic [NUM_CHAN-1:0][ADDR_W:0]       nentries,
    output logic [2:0]                          bx_out,
    output logic                                bx_done,
    output logic                                synced,
    output logic                                err_hdr,
    output logic                                err_ovf,
    output logic                                err_bx
);

    logic [3:0]  hdr;
    logic [2:0]  inBx;
    logic [2:0]  chan;
    logic        isMarker;
    logic        isData;
    logic        isIdle;

    assign hdr      = mem_dat_stream[54:51];
    assign inBx     = mem_dat_stream[50:48];
    assign chan     = hdr_to_chan(hdr);
    assign isMarker = (hdr == HDR_MARKER) && (mem_dat_stream[47:0] == 48'd0);
    assign isData   = hdr_is_data(hdr);
    assign isIdle   = (hdr == HDR_IDLE);

    state_t                                 state_q, state_d;
    logic [PAGE_W-1:0]                      page_q, page_d;
    logic [2:0]                             bx_q, bx_d;
    logic                                   bxDone_q, bxDone_d;
    logic [NUM_CHAN-1:0]                    wrEn_q, wrEn_d;
    logic [50:0]                            dat_q, dat_d;
    logic [NUM_CHAN-1:0][PAGE_W+ADDR_W-1:0] addr_q, addr_d;
    logic                                   errHdr_q, errHdr_d;
    logic                                   errOvf_q, errOvf_d;
    logic                                   errBx_q, errBx_d;

    logic [NUM_CHAN-1:0][ADDR_W:0]          chanCount;
    logic [NUM_CHAN-1:0]                    chanFull;
    logic [NUM_CHAN-1:0]                    chanInc;
    logic                                   cntClear;
    logic                                   cntSnap;

    for (genvar c = 0; c < NUM_CHAN; c++) begin : g_chan
        mem_demux_chan_cnt #(.ADDR_W(ADDR_W)) u_cnt (
            .clk        (clk),
            .reset      (reset),
            .clear_i    (cntClear),
            .inc_i      (chanInc[c]),
            .snap_i     (cntSnap),
            .count_o    (chanCount[c]),
            .full_o     (chanFull[c]),
            .nentries_o (nentries[c])
        );
    end

    always_comb begin
        state_d  = state_q;
        page_d   = page_q;
        bx_d     = bx_q;
        bxDone_d = 1'b0;
        wrEn_d   = '0;
        dat_d    = dat_q;
        addr_d   = addr_q;
        errHdr_d = errHdr_q;
        errOvf_d = errOvf_q;
        errBx_d  = errBx_q;
        chanInc  = '0;
        cntClear = 1'b0;
        cntSnap  = 1'b0;

        case (state_q)
            WAIT_SYNC: begin
                // Only a marker is meaningful before sync; it opens the first BX without closing one.
                if (isMarker) begin
                    state_d  = RUN;
                    page_d   = inBx[PAGE_W-1:0];
                    bx_d     = inBx;
                    cntClear = 1'b1;
                end
            end
            RUN: begin
                if (isMarker) begin
                    page_d   = inBx[PAGE_W-1:0];
                    bx_d     = inBx;
                    bxDone_d = 1'b1;
                    cntClear = 1'b1;
                    cntSnap  = 1'b1;
                    if (inBx != bx_q + 3'd1) begin
                        errBx_d = 1'b1;
                    end
                end else if (isData) begin
                    if (chanFull[chan]) begin
                        errOvf_d = 1'b1;
                    end else begin
                        wrEn_d[chan]  = 1'b1;
                        dat_d         = mem_dat_stream[50:0];
                        addr_d[chan]  = {page_q, chanCount[chan][ADDR_W-1:0]};
                        chanInc[chan] = 1'b1;
                    end
                end else if (!isIdle) begin
                    errHdr_d = 1'b1;
                end
            end
            default: state_d = WAIT_SYNC;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= WAIT_SYNC;
            page_q   <= '0;
            bx_q     <= '0;
            bxDone_q <= 1'b0;
            wrEn_q   <= '0;
            dat_q    <= '0;
            addr_q   <= '0;
            errHdr_q <= 1'b0;
            errOvf_q <= 1'b0;
            errBx_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            page_q   <= page_d;
            bx_q     <= bx_d;
            bxDone_q <= bxDone_d;
            wrEn_q   <= wrEn_d;
            dat_q    <= dat_d;
            addr_q   <= addr_d;
            errHdr_q <= errHdr_d;
            errOvf_q <= errOvf_d;
            errBx_q  <= errBx_d;
        end
    end

    assign dat_out = dat_q;
    assign wr_en   = wrEn_q;
    assign wr_addr = addr_q;
    assign bx_out  = bx_q;
    assign bx_done = bxDone_q;
    assign synced  = (state_q == RUN);
    assign err_hdr = errHdr_q;
    assign err_ovf = errOvf_q;
    assign err_bx  = errBx_q;

endmodule
